// File: rtl/coalescing_store_buffer_if.sv
// rtl/coalescing_store_buffer_if.sv - push, drain, lookup and status bundle for the store buffer
interface coalescing_store_buffer_if #(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_THREADS = 2,
    parameter int LINE_ADDR_W = 28,
    parameter int LINE_BYTES  = 16
);
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int CW = $clog2(NUM_ENTRIES) + 1;
    localparam int DW = LINE_BYTES * 8;

    logic                                    push_valid;
    logic                                    push_ready;
    logic [TW-1:0]                           push_thread;
    logic [LINE_ADDR_W-1:0]                  push_line;
    logic [DW-1:0]                           push_data;
    logic [LINE_BYTES-1:0]                   push_mask;

    logic                                    drain_valid;
    logic                                    drain_ready;
    logic [TW-1:0]                           drain_thread;
    logic [LINE_ADDR_W-1:0]                  drain_line;
    logic [DW-1:0]                           drain_data;
    logic [LINE_BYTES-1:0]                   drain_mask;

    logic [NUM_THREADS-1:0]                  lkp_valid;
    logic [NUM_THREADS-1:0][LINE_ADDR_W-1:0] lkp_line;
    logic [NUM_THREADS-1:0][LINE_BYTES-1:0]  lkp_mask;
    logic [NUM_THREADS-1:0][DW-1:0]          lkp_data;
    logic [NUM_THREADS-1:0][LINE_BYTES-1:0]  lkp_hit_mask;
    logic [NUM_THREADS-1:0]                  lkp_full_hit;

    logic [CW-1:0]                           count;
    logic                                    empty;
    logic                                    full;

    modport master (
        output push_valid, push_thread, push_line, push_data, push_mask,
        output drain_ready, lkp_valid, lkp_line, lkp_mask,
        input  push_ready, drain_valid, drain_thread, drain_line, drain_data, drain_mask,
        input  lkp_data, lkp_hit_mask, lkp_full_hit, count, empty, full
    );

    modport slave (
        input  push_valid, push_thread, push_line, push_data, push_mask,
        input  drain_ready, lkp_valid, lkp_line, lkp_mask,
        output push_ready, drain_valid, drain_thread, drain_line, drain_data, drain_mask,
        output lkp_data, lkp_hit_mask, lkp_full_hit, count, empty, full
    );
endinterface

// File: rtl/coalescing_store_buffer.sv
// rtl/coalescing_store_buffer.sv - age-ordered coalescing store buffer with per-thread forwarding
module coalescing_store_buffer #(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_THREADS = 2,
    parameter int LINE_ADDR_W = 28,
    parameter int LINE_BYTES  = 16
) (
    input logic                    clock,
    input logic                    reset,
    coalescing_store_buffer_if.slave bus
);
    localparam int DW = LINE_BYTES * 8;
    localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
    localparam int PW = $clog2(NUM_ENTRIES);
    localparam int CW = PW + 1;

    logic [PW-1:0]          head_q, head_d, tail_q, tail_d, young;
    logic [CW-1:0]          count_q, count_d;
    logic [TW-1:0]          thread_q [NUM_ENTRIES];
    logic [LINE_ADDR_W-1:0] line_q   [NUM_ENTRIES];
    logic [DW-1:0]          data_q   [NUM_ENTRIES];
    logic [LINE_BYTES-1:0]  mask_q   [NUM_ENTRIES];

    logic push_fire, drain_fire, coalesce, alloc, is_empty, is_full;

    logic [NUM_THREADS-1:0][DW-1:0]         lkp_data_c;
    logic [NUM_THREADS-1:0][LINE_BYTES-1:0] lkp_hit_c;
    logic [NUM_THREADS-1:0]                 lkp_full_c;

    always_comb begin
        is_empty   = (count_q == '0);
        is_full    = (count_q == CW'(NUM_ENTRIES));
        young      = tail_q - PW'(1);
        push_fire  = bus.push_valid && !is_full;
        drain_fire = !is_empty && bus.drain_ready;
        // Merging into an entry that leaves this cycle would lose the new bytes.
        coalesce   = push_fire && !is_empty
                     && (thread_q[young] == bus.push_thread)
                     && (line_q[young] == bus.push_line)
                     && !((young == head_q) && drain_fire);
        alloc      = push_fire && !coalesce;
        head_d     = drain_fire ? head_q + PW'(1) : head_q;
        tail_d     = alloc ? tail_q + PW'(1) : tail_q;
        count_d    = count_q + CW'(alloc) - CW'(drain_fire);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (coalesce) begin
            for (int b = 0; b < LINE_BYTES; b++)
                if (bus.push_mask[b]) data_q[young][b*8 +: 8] <= bus.push_data[b*8 +: 8];
            mask_q[young] <= mask_q[young] | bus.push_mask;
        end else if (alloc) begin
            thread_q[tail_q] <= bus.push_thread;
            line_q[tail_q]   <= bus.push_line;
            data_q[tail_q]   <= bus.push_data;
            mask_q[tail_q]   <= bus.push_mask;
        end
    end

    // Walk oldest to youngest so later matches overwrite earlier bytes.
    always_comb begin
        logic [PW-1:0] idx;
        lkp_data_c = '0;
        lkp_hit_c  = '0;
        lkp_full_c = '0;
        idx        = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                idx = head_q + PW'(k);
                if ((CW'(k) < count_q) && (thread_q[idx] == TW'(t)) && (line_q[idx] == bus.lkp_line[t])) begin
                    for (int b = 0; b < LINE_BYTES; b++) begin
                        if (mask_q[idx][b]) begin
                            lkp_hit_c[t][b]          = 1'b1;
                            lkp_data_c[t][b*8 +: 8]  = data_q[idx][b*8 +: 8];
                        end
                    end
                end
            end
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (!(bus.lkp_valid[t] && bus.lkp_mask[t][b])) begin
                    lkp_hit_c[t][b]         = 1'b0;
                    lkp_data_c[t][b*8 +: 8] = 8'h00;
                end
            end
            lkp_full_c[t] = bus.lkp_valid[t] && ((lkp_hit_c[t] & bus.lkp_mask[t]) == bus.lkp_mask[t]);
        end
    end

    assign bus.push_ready   = !is_full;
    assign bus.drain_valid  = !is_empty;
    assign bus.drain_thread = thread_q[head_q];
    assign bus.drain_line   = line_q[head_q];
    assign bus.drain_data   = data_q[head_q];
    assign bus.drain_mask   = mask_q[head_q];
    assign bus.lkp_data     = lkp_data_c;
    assign bus.lkp_hit_mask = lkp_hit_c;
    assign bus.lkp_full_hit = lkp_full_c;
    assign bus.count        = count_q;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(push_fire && bus.push_mask == '0)) else $error("push with empty byte mask");
            assert (!(bus.push_valid && bus.push_ready && is_full)) else $error("push accepted while full");
            assert (count_q <= CW'(NUM_ENTRIES)) else $error("entry count overflow");
        end
    end
`endif
endmodule

// File: tb/tb_coalescing_store_buffer.sv
// tb/tb_coalescing_store_buffer.sv - randomized and directed bench against a queue model
module tb_coalescing_store_buffer;
    localparam int NE = 8;
    localparam int NT = 2;
    localparam int LA = 28;
    localparam int LB = 16;
    localparam int DW = LB * 8;
    localparam int TW = 1;

    typedef struct {
        logic [TW-1:0] thr;
        logic [LA-1:0] line;
        logic [DW-1:0] data;
        logic [LB-1:0] mask;
    } ent_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    coalescing_store_buffer_if #(.NUM_ENTRIES(NE), .NUM_THREADS(NT), .LINE_ADDR_W(LA), .LINE_BYTES(LB)) bus ();
    coalescing_store_buffer #(.NUM_ENTRIES(NE), .NUM_THREADS(NT), .LINE_ADDR_W(LA), .LINE_BYTES(LB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    ent_t q[$];
    int vectors = 0;
    int errors  = 0;

    task automatic expect_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        reset           = 1'b0;
        bus.push_valid  = 1'b0;
        bus.push_thread = '0;
        bus.push_line   = '0;
        bus.push_data   = '0;
        bus.push_mask   = '0;
        bus.drain_ready = 1'b0;
        bus.lkp_valid   = '0;
        bus.lkp_line    = '0;
        bus.lkp_mask    = '0;
    endtask

    task automatic set_push(input int t, input int line, input logic [DW-1:0] d, input logic [LB-1:0] m);
        bus.push_valid  = 1'b1;
        bus.push_thread = TW'(t);
        bus.push_line   = LA'(line);
        bus.push_data   = d;
        bus.push_mask   = m;
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        expect_eq("count", DW'(bus.count), DW'(n));
        expect_eq("empty", DW'(bus.empty), DW'(n == 0));
        expect_eq("full", DW'(bus.full), DW'(n == NE));
        expect_eq("push_ready", DW'(bus.push_ready), DW'(n != NE));
        expect_eq("drain_valid", DW'(bus.drain_valid), DW'(n != 0));
        if (n > 0) begin
            expect_eq("drain_thread", DW'(bus.drain_thread), DW'(q[0].thr));
            expect_eq("drain_line", DW'(bus.drain_line), DW'(q[0].line));
            expect_eq("drain_data", bus.drain_data, q[0].data);
            expect_eq("drain_mask", DW'(bus.drain_mask), DW'(q[0].mask));
        end
        for (int t = 0; t < NT; t++) begin
            logic [DW-1:0] d;
            logic [LB-1:0] h, m;
            logic          fh;
            d = '0;
            h = '0;
            m = bus.lkp_mask[t];
            if (bus.lkp_valid[t]) begin
                foreach (q[i]) begin
                    if (q[i].thr == TW'(t) && q[i].line == bus.lkp_line[t]) begin
                        for (int b = 0; b < LB; b++) begin
                            if (q[i].mask[b] && m[b]) begin
                                h[b] = 1'b1;
                                d[b*8 +: 8] = q[i].data[b*8 +: 8];
                            end
                        end
                    end
                end
            end
            fh = bus.lkp_valid[t] && ((h & m) == m);
            expect_eq($sformatf("lkp_data[%0d]", t), bus.lkp_data[t], d);
            expect_eq($sformatf("lkp_hit_mask[%0d]", t), DW'(bus.lkp_hit_mask[t]), DW'(h));
            expect_eq($sformatf("lkp_full_hit[%0d]", t), DW'(bus.lkp_full_hit[t]), DW'(fh));
        end
    endtask

    task automatic model_update();
        int   n;
        bit   pf, df, coal;
        ent_t e;
        n = q.size();
        if (reset) begin
            q.delete();
            return;
        end
        pf   = bus.push_valid && (n < NE);
        df   = (n > 0) && bus.drain_ready;
        coal = pf && (n > 0) && q[n-1].thr == bus.push_thread && q[n-1].line == bus.push_line && !(n == 1 && df);
        if (coal) begin
            e = q[n-1];
            for (int b = 0; b < LB; b++)
                if (bus.push_mask[b]) e.data[b*8 +: 8] = bus.push_data[b*8 +: 8];
            e.mask = e.mask | bus.push_mask;
            q[n-1] = e;
        end
        if (df) void'(q.pop_front());
        if (pf && !coal) begin
            e.thr  = bus.push_thread;
            e.line = bus.push_line;
            e.data = bus.push_data;
            e.mask = bus.push_mask;
            q.push_back(e);
        end
    endtask

    task automatic step();
        @(negedge clock);
        check_all();
        model_update();
        @(posedge clock);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        @(posedge clock);
        #1;
        idle();
        expect_eq("rst_count", DW'(bus.count), '0);
        expect_eq("rst_empty", DW'(bus.empty), DW'(1));
        expect_eq("rst_drain_valid", DW'(bus.drain_valid), '0);
        expect_eq("rst_push_ready", DW'(bus.push_ready), DW'(1));

        // single push then drain
        set_push(0, 'h10, DW'(32'hAAAAAAAA), 16'h000F);
        step();
        idle();
        expect_eq("tp1_count", DW'(bus.count), DW'(1));
        expect_eq("tp1_drain_mask", DW'(bus.drain_mask), DW'(16'h000F));
        bus.drain_ready = 1'b1;
        step();
        idle();
        expect_eq("tp1_empty", DW'(bus.empty), DW'(1));

        // coalesce into youngest
        set_push(0, 'h10, DW'(32'hA3A2A1A0), 16'h000F);
        step();
        set_push(0, 'h10, DW'(64'hB7B6B5B4_00000000), 16'h00F0);
        step();
        idle();
        expect_eq("tp2_count", DW'(bus.count), DW'(1));
        expect_eq("tp2_drain_mask", DW'(bus.drain_mask), DW'(16'h00FF));
        expect_eq("tp2_drain_data", DW'(bus.drain_data[63:0]), DW'(64'hB7B6B5B4_A3A2A1A0));
        bus.drain_ready = 1'b1;
        step();
        idle();

        // A, B, A keeps three entries
        set_push(0, 'h30, DW'(1), 16'h0001); step();
        set_push(0, 'h31, DW'(2), 16'h0001); step();
        set_push(0, 'h30, DW'(3), 16'h0001); step();
        idle();
        expect_eq("tp3_count", DW'(bus.count), DW'(3));
        for (int i = 0; i < 3; i++) begin
            expect_eq($sformatf("tp3_order%0d", i), DW'(bus.drain_line), (i == 1) ? DW'('h31) : DW'('h30));
            bus.drain_ready = 1'b1;
            step();
            idle();
        end

        // fill, blocked push while full, wrap
        for (int i = 0; i < NE; i++) begin
            set_push(i % NT, 'h40 + i, DW'({$urandom, $urandom}), 16'h0003);
            step();
        end
        idle();
        expect_eq("tp4_full", DW'(bus.full), DW'(1));
        expect_eq("tp4_push_ready", DW'(bus.push_ready), '0);
        set_push(0, 'h99, DW'(5), 16'h0001);
        bus.drain_ready = 1'b1;
        step();
        idle();
        expect_eq("tp4_blocked_count", DW'(bus.count), DW'(NE - 1));
        set_push(1, 'h50, DW'(6), 16'h0001);
        step();
        idle();
        bus.drain_ready = 1'b1;
        for (int i = 0; i < NE; i++) step();
        idle();

        // forwarding: youngest byte wins, other thread misses
        set_push(0, 'h20, DW'(8'h11), 16'h0001); step();
        set_push(0, 'h21, DW'(8'h77), 16'h0001); step();
        set_push(0, 'h20, DW'(16'h3322), 16'h0003); step();
        idle();
        bus.lkp_valid   = 2'b11;
        bus.lkp_line[0] = LA'('h20);
        bus.lkp_line[1] = LA'('h20);
        bus.lkp_mask[0] = 16'h0003;
        bus.lkp_mask[1] = 16'h0003;
        #1;
        expect_eq("tp5_data", DW'(bus.lkp_data[0][15:0]), DW'(16'h3322));
        expect_eq("tp5_hit", DW'(bus.lkp_hit_mask[0]), DW'(16'h0003));
        expect_eq("tp5_full", DW'(bus.lkp_full_hit[0]), DW'(1));
        expect_eq("tp5_t1_hit", DW'(bus.lkp_hit_mask[1]), '0);
        expect_eq("tp5_t1_full", DW'(bus.lkp_full_hit[1]), '0);
        step();

        // reset with three pending stores and live push/drain
        idle();
        set_push(1, 'h60, DW'(9), 16'h0001);
        bus.drain_ready = 1'b1;
        reset = 1'b1;
        step();
        idle();
        expect_eq("tp6_count", DW'(bus.count), '0);
        expect_eq("tp6_empty", DW'(bus.empty), DW'(1));
        expect_eq("tp6_drain_valid", DW'(bus.drain_valid), '0);
        step();

        for (int c = 0; c < 3000; c++) begin
            logic [LB-1:0] m;
            idle();
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) < 6) begin
                m = LB'($urandom);
                if (m == '0) m = 16'h0100;
                set_push($urandom_range(0, NT - 1), 'h100 + $urandom_range(0, 3),
                         {$urandom, $urandom, $urandom, $urandom}, m);
            end
            bus.drain_ready = ($urandom_range(0, 9) < 4);
            for (int t = 0; t < NT; t++) begin
                bus.lkp_valid[t] = $urandom_range(0, 3) != 0;
                bus.lkp_line[t]  = LA'('h100 + $urandom_range(0, 3));
                bus.lkp_mask[t]  = LB'($urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
